// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the PLL reset sequencer and the PLL / core-reset consumers.
// Latency: none (wires only).
// Backpressure: none; all signals are level indications.
interface pll_reset_sequencer_if;
  logic       pll_locked;
  logic       pll_rst;
  logic       sys_reset;
  logic [1:0] state;
  logic       timeout;
  logic [7:0] retry_cnt;

  // Sequencer side: consumes lock, drives the resets and status.
  modport master (
    input  pll_locked,
    output pll_rst,
    output sys_reset,
    output state,
    output timeout,
    output retry_cnt
  );

  // PLL / observer side: drives lock, sees the resets and status.
  modport slave (
    output pll_locked,
    input  pll_rst,
    input  sys_reset,
    input  state,
    input  timeout,
    input  retry_cnt
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Pulses PLL reset, waits for and debounces lock, then releases core reset; re-asserts on lock loss.
// Latency: sys_reset falls STABLE_CYCLES+2 edges after lock is first sampled; rises 2 edges after loss is sampled.
// Backpressure: none; optional macro PLL_RESET_SEQUENCER_AUTO_RETRY_EN re-pulses the PLL on lock timeout.
module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT   = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  pll_reset_sequencer_if.master bus
);

  localparam int MAX_AB = (PLL_RST_CYCLES > STABLE_CYCLES) ? PLL_RST_CYCLES : STABLE_CYCLES;
  localparam int MAX_P  = (MAX_AB > LOCK_TIMEOUT) ? MAX_AB : LOCK_TIMEOUT;
  localparam int CNT_W  = $clog2(MAX_P) + 1;

  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t           state_q;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;
  logic             timeout_q;
  logic             timeout_nxt;
  logic [7:0]       retry_q;
  logic [7:0]       retry_nxt;
  logic             pll_rst_q;
  logic             pll_rst_nxt;
  logic             sys_reset_q;
  logic             sys_reset_nxt;
  logic             locked_meta;
  logic             locked_s;

  // Bring the PLL lock flag into the reference clock domain before any decision uses it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked_meta <= 1'b0;
      locked_s    <= 1'b0;
    end else begin
      locked_meta <= bus.pll_locked;
      locked_s    <= locked_meta;
    end
  end

  // State, shared counter and registered outputs; outputs change on the same edge as the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= PLL_RST;
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
      retry_q     <= 8'd0;
      pll_rst_q   <= 1'b1;
      sys_reset_q <= 1'b1;
    end else begin
      state_q     <= state_nxt;
      cnt_q       <= cnt_nxt;
      timeout_q   <= timeout_nxt;
      retry_q     <= retry_nxt;
      pll_rst_q   <= pll_rst_nxt;
      sys_reset_q <= sys_reset_nxt;
    end
  end

  // Next-state logic; the counter restarts from zero on every state change.
  always_comb begin
    state_nxt   = state_q;
    cnt_nxt     = cnt_q;
    timeout_nxt = timeout_q;
    retry_nxt   = retry_q;

    case (state_q)
      PLL_RST: begin
        if (cnt_q == RST_LAST) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_q + 1'b1;
        end
      end

      WAIT_LOCK: begin
        if (locked_s) begin
          state_nxt = STABLE;
          cnt_nxt   = '0;
        end else if (cnt_q == TOUT_LAST) begin
          timeout_nxt = 1'b1;
`ifdef PLL_RESET_SEQUENCER_AUTO_RETRY_EN
          // Give the PLL a fresh reset pulse and record the attempt.
          state_nxt = PLL_RST;
          cnt_nxt   = '0;
          retry_nxt = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;
`else
          // Park here with the counter pinned; a late lock still proceeds.
          cnt_nxt = cnt_q;
`endif
        end else begin
          cnt_nxt = cnt_q + 1'b1;
        end
      end

      STABLE: begin
        if (!locked_s) begin
          // Lock glitched during qualification: start over without re-pulsing the PLL.
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt_q == STB_LAST) begin
          state_nxt   = RUN;
          cnt_nxt     = '0;
          timeout_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt_q + 1'b1;
        end
      end

      RUN: begin
        timeout_nxt = 1'b0;
        if (!locked_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end
      end

      default: begin
        state_nxt = PLL_RST;
        cnt_nxt   = '0;
      end
    endcase

`ifndef PLL_RESET_SEQUENCER_AUTO_RETRY_EN
    retry_nxt = 8'd0;
`endif
  end

  // Output values follow the state being entered so they toggle with the state register.
  always_comb begin
    pll_rst_nxt   = 1'b0;
    sys_reset_nxt = 1'b1;
    if (state_nxt == PLL_RST) pll_rst_nxt = 1'b1;
    if (state_nxt == RUN) sys_reset_nxt = 1'b0;
  end

  assign bus.pll_rst   = pll_rst_q;
  assign bus.sys_reset = sys_reset_q;
  assign bus.state     = state_q;
  assign bus.timeout   = timeout_q;
  assign bus.retry_cnt = retry_q;

endmodule
